// File: rtl/counter_updown_mod.sv
// rtl/counter_updown_mod.sv - parametrised up/down modulo counter with load, clear, wrap/saturate and event flags
//
// Optional feature macro: COUNTER_PRESCALE_EN
//   When defined, adds parameter PRESCALE. A count step then happens only on
//   every PRESCALE-th cycle that has en=1.
//
// Parameters:
//   WIDTH     counter bit width (>= 2)
//   MAX_VAL   highest count value; the modulo is MAX_VAL+1 (1 <= MAX_VAL <= 2**WIDTH-1)
//   PRESCALE  enabled cycles per step (>= 1), only with COUNTER_PRESCALE_EN
//
// Ports:
//   clk         clock; all state changes on the rising edge
//   reset       synchronous, active-high reset; overrides every other input
//   en          count enable
//   up_dn       direction: 1 = up, 0 = down
//   sat_mode    1 = saturate at the limits, 0 = wrap around
//   load        parallel load strobe; the loaded value is clamped to MAX_VAL
//   load_val    value to load
//   clear       synchronous clear of the count to 0
//   count       current count (registered)
//   at_max      combinational, count == MAX_VAL
//   at_zero     combinational, count == 0
//   wrap        registered one-cycle pulse on a wrap event
//   sat_hit     registered one-cycle pulse when saturation blocks a step
//   ovf_sticky  sticky flag, set by any wrap or sat_hit event
//   ovf_clr     clears ovf_sticky; a same-edge set wins

module counter_updown_mod #(
    parameter int WIDTH    = 8,
    parameter int MAX_VAL  = 2**WIDTH - 1
`ifdef COUNTER_PRESCALE_EN
    ,
    parameter int PRESCALE = 4
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             sat_mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clear,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_zero,
    output logic             wrap,
    output logic             sat_hit,
    output logic             ovf_sticky,
    input  logic             ovf_clr
);

    localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] ZERO_V = '0;
    localparam logic [WIDTH-1:0] ONE_V  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic             step;
    logic [WIDTH-1:0] count_nxt;
    logic             wrap_nxt;
    logic             sat_nxt;

    // ------------------------------------------------------------------
    // Step qualification
    // ------------------------------------------------------------------
`ifdef COUNTER_PRESCALE_EN
    localparam int PW = $clog2(PRESCALE) + 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_cnt;
    logic          pre_tick;

    // The phase only advances on enabled cycles, and restarts whenever the
    // count is forced (clear/load) so a loaded value always gets a full period.
    assign pre_tick = en && (pre_cnt == PRE_LAST);

    always_ff @(posedge clk) begin
        if (reset || clear || load) begin
            pre_cnt <= '0;
        end else if (en) begin
            if (pre_cnt == PRE_LAST) begin
                pre_cnt <= '0;
            end else begin
                pre_cnt <= pre_cnt + PW'(1);
            end
        end
    end

    assign step = pre_tick;
`else
    assign step = en;
`endif

    // ------------------------------------------------------------------
    // Next-state and event decode (priority: clear > load > step > hold)
    // ------------------------------------------------------------------
    always_comb begin
        count_nxt = count;
        wrap_nxt  = 1'b0;
        sat_nxt   = 1'b0;
        if (clear) begin
            count_nxt = ZERO_V;
        end else if (load) begin
            count_nxt = (load_val > MAX_V) ? MAX_V : load_val;
        end else if (step) begin
            if (up_dn) begin
                if (count < MAX_V) begin
                    count_nxt = count + ONE_V;
                end else if (sat_mode) begin
                    sat_nxt = 1'b1;
                end else begin
                    count_nxt = ZERO_V;
                    wrap_nxt  = 1'b1;
                end
            end else begin
                if (count != ZERO_V) begin
                    count_nxt = count - ONE_V;
                end else if (sat_mode) begin
                    sat_nxt = 1'b1;
                end else begin
                    count_nxt = MAX_V;
                    wrap_nxt  = 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            count      <= ZERO_V;
            wrap       <= 1'b0;
            sat_hit    <= 1'b0;
            ovf_sticky <= 1'b0;
        end else begin
            count   <= count_nxt;
            wrap    <= wrap_nxt;
            sat_hit <= sat_nxt;
            // A new event beats a simultaneous clear request.
            if (wrap_nxt || sat_nxt) begin
                ovf_sticky <= 1'b1;
            end else if (ovf_clr) begin
                ovf_sticky <= 1'b0;
            end
        end
    end

    assign at_max  = (count == MAX_V);
    assign at_zero = (count == ZERO_V);

endmodule

// File: tb/tb_counter_updown_mod.sv
// tb/tb_counter_updown_mod.sv - directed self-checking bench for counter_updown_mod (WIDTH=4, MAX_VAL=9)

module tb_counter_updown_mod;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       up_dn;
    logic       sat_mode;
    logic       load;
    logic [3:0] load_val;
    logic       clear;
    logic       ovf_clr;
    logic [3:0] count;
    logic       at_max;
    logic       at_zero;
    logic       wrap;
    logic       sat_hit;
    logic       ovf_sticky;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

`ifdef COUNTER_PRESCALE_EN
    counter_updown_mod #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(1)) dut (
`else
    counter_updown_mod #(.WIDTH(4), .MAX_VAL(9)) dut (
`endif
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .sat_mode(sat_mode),
        .load(load), .load_val(load_val), .clear(clear), .count(count),
        .at_max(at_max), .at_zero(at_zero), .wrap(wrap), .sat_hit(sat_hit),
        .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr)
    );

`ifdef COUNTER_PRESCALE_EN
    logic [3:0] p_count;
    logic       p_at_max, p_at_zero, p_wrap, p_sat_hit, p_ovf;

    counter_updown_mod #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(3)) dut_pre (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .sat_mode(sat_mode),
        .load(load), .load_val(load_val), .clear(clear), .count(p_count),
        .at_max(p_at_max), .at_zero(p_at_zero), .wrap(p_wrap), .sat_hit(p_sat_hit),
        .ovf_sticky(p_ovf), .ovf_clr(ovf_clr)
    );
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; up_dn = 1'b1; sat_mode = 1'b0;
        load = 1'b0; load_val = 4'd0; clear = 1'b0; ovf_clr = 1'b0;
        #2;
        tick();
        chk("rst_count", 32'(count), 0);
        chk("rst_wrap", 32'(wrap), 0);
        chk("rst_sat", 32'(sat_hit), 0);
        chk("rst_ovf", 32'(ovf_sticky), 0);
        chk("rst_at_zero", 32'(at_zero), 1);

        // Up, wrap mode: 1..9,0,1,2
        reset = 1'b0; en = 1'b1; up_dn = 1'b1; sat_mode = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            chk("up_count", 32'(count), 32'(i % 10));
            chk("up_wrap", 32'(wrap), (i == 10) ? 1 : 0);
            chk("up_at_max", 32'(at_max), (i == 9) ? 1 : 0);
        end
        chk("up_ovf", 32'(ovf_sticky), 1);

        // ovf_clr alone clears sticky; en=0 holds count
        en = 1'b0; ovf_clr = 1'b1;
        tick();
        chk("clr_ovf", 32'(ovf_sticky), 0);
        chk("hold_count", 32'(count), 2);
        ovf_clr = 1'b0;

        // clear: count 0, no pulse, sticky untouched
        clear = 1'b1;
        tick();
        chk("clear_count", 32'(count), 0);
        chk("clear_wrap", 32'(wrap), 0);
        clear = 1'b0;

        // Down, wrap mode from 0: 9,8,7
        en = 1'b1; up_dn = 1'b0;
        tick();
        chk("dn_count0", 32'(count), 9);
        chk("dn_wrap0", 32'(wrap), 1);
        chk("dn_ovf", 32'(ovf_sticky), 1);
        tick();
        chk("dn_count1", 32'(count), 8);
        chk("dn_wrap1", 32'(wrap), 0);
        tick();
        chk("dn_count2", 32'(count), 7);

        // Down, saturate from 0: holds, sat_hit each cycle
        en = 1'b0; clear = 1'b1;
        tick();
        clear = 1'b0; en = 1'b1; sat_mode = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("sat_dn_count", 32'(count), 0);
            chk("sat_dn_pulse", 32'(sat_hit), 1);
            chk("sat_dn_wrap", 32'(wrap), 0);
        end
        en = 1'b0;
        tick();
        chk("sat_idle_pulse", 32'(sat_hit), 0);

        // Load clamps to MAX_VAL, then in-range load
        load = 1'b1; load_val = 4'd14;
        tick();
        chk("load_clamp", 32'(count), 9);
        chk("load_at_max", 32'(at_max), 1);
        chk("load_wrap", 32'(wrap), 0);
        chk("load_sat", 32'(sat_hit), 0);
        load_val = 4'd5;
        tick();
        chk("load_5", 32'(count), 5);

        // Up, saturate at MAX_VAL
        load_val = 4'd9;
        tick();
        load = 1'b0; en = 1'b1; up_dn = 1'b1;
        tick();
        chk("sat_up_count", 32'(count), 9);
        chk("sat_up_pulse", 32'(sat_hit), 1);

        // Priority: reset > clear > load > en
        reset = 1'b1; clear = 1'b1; load = 1'b1; load_val = 4'd3; en = 1'b1;
        tick();
        chk("pri_reset", 32'(count), 0);
        chk("pri_reset_ovf", 32'(ovf_sticky), 0);
        reset = 1'b0;
        tick();
        chk("pri_clear", 32'(count), 0);
        clear = 1'b0;
        tick();
        chk("pri_load", 32'(count), 3);

        // ovf_clr on the same edge as a wrap: set wins
        load_val = 4'd9; en = 1'b0;
        tick();
        load = 1'b0; sat_mode = 1'b0; up_dn = 1'b1; en = 1'b1; ovf_clr = 1'b1;
        tick();
        chk("race_count", 32'(count), 0);
        chk("race_wrap", 32'(wrap), 1);
        chk("race_ovf", 32'(ovf_sticky), 1);
        en = 1'b0;
        tick();
        chk("race_clr_ovf", 32'(ovf_sticky), 0);
        chk("race_wrap_end", 32'(wrap), 0);
        ovf_clr = 1'b0;

`ifdef COUNTER_PRESCALE_EN
        // PRESCALE=3: 9 enabled cycles -> 3 steps
        reset = 1'b1;
        tick();
        reset = 1'b0; en = 1'b1; up_dn = 1'b1; sat_mode = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        chk("pre_9cyc", 32'(p_count), 3);

        // Load mid-period restarts the phase
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("pre_4cyc", 32'(p_count), 1);
        load = 1'b1; load_val = 4'd0;
        tick();
        load = 1'b0;
        tick();
        tick();
        chk("pre_restart_hold", 32'(p_count), 0);
        tick();
        chk("pre_restart_step", 32'(p_count), 1);
        en = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/counter_updown_mod.md
Name: counter_updown_mod

Overview:
Parametrised synchronous counter that generalises the basic 4-bit free-running up-counter. It adds programmable width, modulo limit, up/down direction, parallel load, count enable, and wrap vs saturate mode, with terminal/event flags. It is the general-purpose timing and event counter for the Basic-counter design family. It is instantiated wherever a bounded, loadable count is needed.

Parameters:
WIDTH, 8, counter bit width (min 2).
MAX_VAL, 2**WIDTH-1, highest count value (modulo = MAX_VAL+1); must satisfy 1 <= MAX_VAL <= 2**WIDTH-1.

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
en  input  1  count enable; a step occurs only when high
up_dn  input  1  direction: 1 = up, 0 = down
sat_mode  input  1  1 = saturate at limits, 0 = wrap
load  input  1  parallel load strobe
load_val  input  WIDTH  value to load
clear  input  1  synchronous clear of count to 0
count  output  WIDTH  current count (registered)
at_max  output  1  combinational: count == MAX_VAL
at_zero  output  1  combinational: count == 0
wrap  output  1  registered 1-cycle pulse on wrap event
sat_hit  output  1  registered 1-cycle pulse when a step is blocked by saturation
ovf_sticky  output  1  sticky flag, set by any wrap or sat_hit event
ovf_clr  input  1  clears ovf_sticky

Behaviour:
- Reset: one clock; synchronous, active-high; port names are clk and reset. On the rising edge with reset=1: count=0, wrap=0, sat_hit=0, ovf_sticky=0. Reset overrides every other input.
- Priority per edge: reset > clear > load > en step > hold.
- clear: count<=0. No wrap or sat_hit pulse. ovf_sticky is unaffected.
- load: count<=min(load_val, MAX_VAL). Out-of-range values clamp to MAX_VAL. No pulse.
- Step when en=1 and neither load nor clear is active:
  - Up, count<MAX_VAL: count+1.
  - Up, count==MAX_VAL: if sat_mode=0, count<=0 and wrap=1 next cycle; if sat_mode=1, count holds and sat_hit=1 next cycle.
  - Down, count>0: count-1.
  - Down, count==0: if sat_mode=0, count<=MAX_VAL and wrap=1; if sat_mode=1, count holds and sat_hit=1.
- Pulse timing: wrap and sat_hit are high for exactly the one cycle in which count shows the post-event value. They are 0 when no event occurs. Consecutive events produce consecutive pulses.
- en=0: count holds, pulses are 0.
- ovf_sticky: set on the edge where wrap or sat_hit is set. Cleared by ovf_clr. If a set and ovf_clr occur on the same edge, set wins.
- Latency: count updates 1 cycle after the controlling inputs are sampled. at_max and at_zero follow count combinationally.
- Arithmetic never produces values above MAX_VAL. Internal compare is WIDTH bits with no overflow of the WIDTH-bit range.
- Mode and direction changes take effect on the next edge; no state is kept per mode.

Optional Feature:
COUNTER_PRESCALE_EN:
- Defined: adds parameter PRESCALE (default 4, >=1) and an internal prescale counter of width $clog2(PRESCALE)+1.
  - A step occurs only on every PRESCALE-th cycle with en=1; the prescale counter advances only while en=1.
  - The prescale counter resets to 0 on reset, clear, or load.
  - PRESCALE=1 behaves identically to the undefined case.
- Undefined: no prescaler logic; a step occurs on every en=1 cycle.

Test Plan:
- WIDTH=4, MAX_VAL=9, sat_mode=0, up: reset, then en=1 for 12 cycles -> count 1..9,0,1,2; wrap high only in the cycle count==0; ovf_sticky=1 afterward.
- Same config, down from 0 with sat_mode=0 -> count 9,8,7; wrap high with count==9. Then sat_mode=1 from 0 -> count stays 0, sat_hit pulses every enabled cycle.
- load=1 with load_val=14 (MAX_VAL=9) -> count=9, at_max=1, no pulse. load_val=5 -> count=5.
- Priority: assert reset, clear, load (load_val=3), and en together -> count=0. Drop reset, keep the rest -> count=0 (clear). Drop clear -> count=3.
- ovf_clr asserted on the same edge as a wrap -> ovf_sticky=1. ovf_clr alone on the next edge -> ovf_sticky=0.
- With COUNTER_PRESCALE_EN, PRESCALE=3, en=1 for 9 cycles from 0 up -> count=3; load mid-sequence restarts the prescale phase.
